// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : SHA-256 IV, FSM state encoding, working-variable struct and
//               compression-round helper functions.
// Revision    : 1.0
// ============================================================================
package sha256_pkg;

    localparam logic [255:0] c_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [5:0] c_LAST_ROUND = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    // Field a sits in the MSBs so the flat view lines up with {H0..H7}.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round
// Description : One combinational SHA-256 compression round.
// Revision    : 1.0
// ============================================================================
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       i_work,
    input  logic [31:0] i_wi,
    input  logic [31:0] i_ki,
    output work_t       o_work
);

    logic [31:0] w_t1;
    logic [31:0] w_t2;

    assign w_t1 = i_work.h + bsig1(i_work.e) + ch(i_work.e, i_work.f, i_work.g) + i_ki + i_wi;
    assign w_t2 = bsig0(i_work.a) + maj(i_work.a, i_work.b, i_work.c);

    assign o_work.a = w_t1 + w_t2;
    assign o_work.b = i_work.a;
    assign o_work.c = i_work.b;
    assign o_work.d = i_work.c;
    assign o_work.e = i_work.d + w_t1;
    assign o_work.f = i_work.e;
    assign o_work.g = i_work.f;
    assign o_work.h = i_work.g;

endmodule
`default_nettype wire

// File: rtl/sha256_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round_engine
// Description : Iterative SHA-256 block compressor, one round per valid W/K.
// Revision    : 1.0
// ============================================================================
module sha256_round_engine
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         first_block,
    input  logic         wk_valid,
    input  logic [31:0]  Wi,
    input  logic [31:0]  Ki,
    output logic [5:0]   round_idx,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    state_t       r_state;
    state_t       w_state_nxt;
    work_t        r_work;
    work_t        w_work_rnd;
    logic [255:0] r_hash;
    logic [255:0] w_work_flat;
    logic [255:0] w_hash_sum;
    logic [5:0]   r_round;
    logic         r_done;
    logic         w_accept;
    logic         w_step;
    logic         w_final;

    sha256_round u_round (
        .i_work (r_work),
        .i_wi   (Wi),
        .i_ki   (Ki),
        .o_work (w_work_rnd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_ROUND;
            ST_ROUND: if (wk_valid && (r_round == c_LAST_ROUND)) w_state_nxt = ST_FINAL;
            ST_FINAL: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept = (r_state == ST_IDLE) && start;
        w_step   = (r_state == ST_ROUND) && wk_valid;
        w_final  = (r_state == ST_FINAL);
        busy     = (r_state != ST_IDLE);
    end

    assign w_work_flat = r_work;

    for (genvar gi = 0; gi < 8; gi++) begin : g_hash_add
        assign w_hash_sum[gi*32 +: 32] = r_hash[gi*32 +: 32] + w_work_flat[gi*32 +: 32];
    end

    // Counter wraps 63 -> 0 naturally in 6 bits as the last round is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work  <= '0;
            r_hash  <= c_IV;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_final;
            if (w_accept) begin
                r_work  <= first_block ? work_t'(c_IV) : work_t'(r_hash);
                r_round <= '0;
                if (first_block) r_hash <= c_IV;
            end else if (w_step) begin
                r_work  <= w_work_rnd;
                r_round <= r_round + 6'd1;
            end else if (w_final) begin
                r_hash <= w_hash_sum;
            end
        end
    end

    assign round_idx = r_round;
    assign done      = r_done;
    assign digest    = r_hash;

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sha256_round_engine
// Description : Directed bench using FIPS 180-4 example digests.
// Revision    : 1.0
// ============================================================================
module tb_sha256_round_engine;

    localparam logic [255:0] c_IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] c_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] c_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] c_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         first_block;
    logic         wk_valid;
    logic [31:0]  Wi;
    logic [31:0]  Ki;
    logic [5:0]   round_idx;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    logic [31:0]  blk   [16];
    logic [31:0]  sched [64];
    int           n_vec = 0;
    int           n_err = 0;
    int           cycles;
    int           done_cnt;

    always #5 clk = ~clk;

    // Schedule/constant stage model: words are presented for the index the engine asks for.
    assign Wi = sched[round_idx];
    assign Ki = c_K[round_idx];

    sha256_round_engine dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .first_block (first_block),
        .wk_valid    (wk_valid),
        .Wi          (Wi),
        .Ki          (Ki),
        .round_idx   (round_idx),
        .busy        (busy),
        .done        (done),
        .digest      (digest)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_sched();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) sched[t] = blk[t];
            else        sched[t] = ssig1(sched[t-2]) + sched[t-7] + ssig0(sched[t-15]) + sched[t-16];
        end
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where done is high
    // (or the budget ran out). cyc counts rising edges, accept edge included.
    task automatic run_block(input bit first, input bit stall_en, input bit poke_start,
                             output int cyc);
        int         stall_left [64];
        logic [5:0] prev_idx;
        bit         stalled;
        bit         poked;
        for (int i = 0; i < 64; i++) stall_left[i] = 0;
        if (stall_en) begin
            stall_left[0]  = 3;
            stall_left[31] = 3;
            stall_left[63] = 3;
        end
        build_sched();
        start       = 1'b1;
        first_block = first;
        wk_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        stalled  = 1'b0;
        poked    = 1'b0;
        prev_idx = '0;
        check("busy_after_accept", {255'd0, busy}, 256'd1);
        while (!done && cyc < 300) begin
            if (stalled) check("stall_idx_frozen", {250'd0, round_idx}, {250'd0, prev_idx});
            stalled = 1'b0;
            if (busy && stall_left[round_idx] > 0) begin
                stall_left[round_idx]--;
                wk_valid = 1'b0;
                stalled  = 1'b1;
                prev_idx = round_idx;
            end else begin
                wk_valid = 1'b1;
            end
            if (poke_start && !poked && busy && round_idx == 6'd20) begin
                start       = 1'b1;
                first_block = 1'b0;
                poked       = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", {255'd0, done}, 256'd1);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    task automatic load_abc();
        blk = '{default: 32'h0};
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        first_block = 1'b0;
        wk_valid    = 1'b0;
        blk         = '{default: 32'h0};
        build_sched();
        #12;
        check("reset_digest", digest, c_IV);
        check("reset_busy", {255'd0, busy}, 256'd0);
        check("reset_done", {255'd0, done}, 256'd0);
        check("reset_round_idx", {250'd0, round_idx}, 256'd0);

        // "abc", started on the very first edge after reset release
        @(negedge clk);
        reset = 1'b0;
        load_abc();
        run_block(1'b1, 1'b0, 1'b0, cycles);
        check("abc_latency", cycles, 66);
        check("abc_digest", digest, c_ABC);
        @(negedge clk);
        check("done_one_cycle", {255'd0, done}, 256'd0);
        check("busy_idle", {255'd0, busy}, 256'd0);

        blk = '{default: 32'h0};
        blk[0] = 32'h80000000;
        run_block(1'b1, 1'b0, 1'b0, cycles);
        check("empty_digest", digest, c_EMPTY);

        // Two blocks, second chained and started in the done cycle of the first
        blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        run_block(1'b1, 1'b0, 1'b0, cycles);
        blk = '{default: 32'h0};
        blk[15] = 32'h000001c0;
        run_block(1'b0, 1'b0, 1'b0, cycles);
        check("two_block_latency", cycles, 66);
        check("two_block_digest", digest, c_TWO);

        @(negedge clk);
        load_abc();
        run_block(1'b1, 1'b1, 1'b0, cycles);
        check("stall_latency", cycles, 75);
        check("stall_digest", digest, c_ABC);

        @(negedge clk);
        load_abc();
        run_block(1'b1, 1'b0, 1'b1, cycles);
        check("poke_latency", cycles, 66);
        check("poke_digest", digest, c_ABC);
        count_done(80, done_cnt);
        check("poke_single_done", done_cnt, 0);
        check("poke_busy_after", {255'd0, busy}, 256'd0);

        // Abort mid-block with reset at round 40
        @(negedge clk);
        load_abc();
        run_block(1'b1, 1'b0, 1'b0, cycles);
        @(negedge clk);
        start       = 1'b1;
        first_block = 1'b1;
        wk_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (round_idx != 6'd40 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("reached_round40", {250'd0, round_idx}, 256'd40);
        reset = 1'b1;
        #1;
        check("abort_busy", {255'd0, busy}, 256'd0);
        check("abort_digest", digest, c_IV);
        check("abort_done", {255'd0, done}, 256'd0);
        check("abort_round_idx", {250'd0, round_idx}, 256'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(80, done_cnt);
        check("abort_no_done", done_cnt, 0);

        // H was restored to IV, so chaining from it must reproduce the "abc" digest
        load_abc();
        run_block(1'b0, 1'b0, 1'b0, cycles);
        check("post_reset_digest", digest, c_ABC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not complete");
    end

endmodule
`default_nettype wire

// File: doc/sha256_round_engine.md
SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to compress one 512-bit block; sampled only in IDLE.
REQ-004 SHALL have port first_block, input, 1 bit: sampled with start; 1 loads the FIPS 180-4 IV into H0..H7, 0 chains from the current H.
REQ-005 SHALL have port wk_valid, input, 1 bit: Wi/Ki hold the schedule word and constant for the current round_idx.
REQ-006 SHALL have port Wi, input, 32 bits: message schedule word W[t].
REQ-007 SHALL have port Ki, input, 32 bits: round constant K[t].
REQ-008 SHALL have port round_idx, output, 6 bits: current round t; drives the schedule/constant stage index.
REQ-009 SHALL have port busy, output, 1 bit: high from the start-accept edge until done asserts.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse; digest updated this cycle.
REQ-011 SHALL have port digest, output, 256 bits: {H0..H7}, H0 in bits 255:224; continuously reflects the H registers.

Function
REQ-012 SHALL implement FSM IDLE -> ROUND -> FINAL -> IDLE; done is a registered pulse emitted on the FINAL->IDLE edge.
REQ-013 In IDLE with start=1, SHALL on that edge: set a..h from IV (first_block=1) or H (first_block=0), also load H from IV when first_block=1, clear round_idx to 0, go to ROUND, assert busy.
REQ-014 In ROUND, SHALL perform one compression round per edge with wk_valid=1: T1=h+Σ1(e)+Ch(e,f,g)+Ki+Wi, T2=Σ0(a)+Maj(a,b,c); h..a shifted per FIPS 180-4; all additions modulo 2^32.
REQ-015 In ROUND with wk_valid=0, SHALL hold a..h and round_idx unchanged (stall), any number of cycles.
REQ-016 SHALL increment round_idx by 1 per consumed round; on consuming round 63, SHALL go to FINAL and wrap round_idx to 0.
REQ-017 In FINAL, SHALL set Hn <= Hn + working var (mod 2^32) for all eight words, assert done next cycle, deassert busy, return to IDLE.
REQ-018 With wk_valid held at 1, done SHALL be high in the cycle following the 66th rising edge after the start-accept edge (1 accept + 64 rounds + 1 FINAL).
REQ-019 SHALL ignore start while busy=1; no queuing.
REQ-020 SHALL allow start in the cycle done is high (back-to-back blocks; IDLE accepts it).
REQ-021 SHALL ignore Wi, Ki and wk_valid outside ROUND.

Reset
REQ-022 On reset=1, SHALL asynchronously set state=IDLE, busy=0, done=0, round_idx=0, a..h=0, H0..H7=IV (digest=6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19).
REQ-023 Reset during ROUND or FINAL SHALL abort the block with no done pulse; H SHALL NOT retain partial results.
REQ-024 After reset deasserts, SHALL accept start on the first rising edge.

Structure
REQ-025 Shared package sha256_pkg SHALL hold the eight IV constants, the FSM state enum, and Σ0/Σ1/Ch/Maj functions.
REQ-026 SHALL instantiate one combinational sub-module sha256_round (inputs a..h, Wi, Ki; outputs next a..h); the engine holds the FSM, counter and registers.

Verification
REQ-027 "abc" padded single block, first_block=1, wk_valid=1 always -> done after 66 edges; digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-028 Empty message single block, first_block=1 -> digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-029 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", block 2 first_block=0 started in done cycle -> digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-030 "abc" with wk_valid deasserted for 3 cycles at rounds 0, 31, 63 -> same digest; done 9 cycles later than REQ-027; round_idx frozen during stalls.
REQ-031 start pulsed at round 20 -> ignored; exactly one done; digest unchanged from REQ-027.
REQ-032 reset asserted at round 40 -> busy=0 and digest=IV immediately, no done; subsequent "abc" run gives REQ-027 digest.
